if_stage: RTL and testbench

- Instruction-fetch stage of the mips32 pipeline. It sits directly upstream of decode and the register-file read.
- Holds the PC and drives the instruction-memory address. It captures the fetched word and PC+4 into the IF/ID pipeline register.
- Handles stall (hazard hold), flush (bubble insertion) and branch/jump redirects from downstream.
- Instruction memory read is combinational: imemData is valid in the same cycle as imemAddr.

---
 rtl/if_stage.sv | 131 +++++++++++++
 tb/tb_if_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, instruction-memory addressing and the IF/ID pipeline register.
// Defining IF_PERF_CNT_EN adds fetchCount/bubbleCount performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              branchTaken,
  input  logic [31:0]       branchTarget,
  input  logic              jump,
  input  logic [31:0]       jumpTarget,
  output logic [ADDR_W-1:0] imemAddr,
  output logic              imemRd,
  input  logic [31:0]       imemData,
  output logic [31:0]       pc,
  output logic [31:0]       ifidInstr,
  output logic [31:0]       ifidPc4,
  output logic              ifidValid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetchCount,
  output logic [31:0]       bubbleCount
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;
  logic        load_fetch;
  logic        load_bubble;

  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_tgt = (branchTaken ? branchTarget : jumpTarget) & 32'hFFFF_FFFC;

  assign imemAddr  = pc_q[ADDR_W+1:2];
  assign imemRd    = ~rst;
  assign pc        = pc_q;
  assign ifidInstr = instr_q;
  assign ifidPc4   = pc4_q;
  assign ifidValid = valid_q;

  // Redirect beats stall, stall beats flush; reset is applied in the register process.
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    load_fetch  = 1'b0;
    load_bubble = 1'b0;
    if (branchTaken || jump) begin
      pc_d        = redirect_tgt;
      instr_d     = 32'd0;
      pc4_d       = 32'd0;
      valid_d     = 1'b0;
      load_bubble = 1'b1;
    end else if (stall) begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
    end else if (flush) begin
      pc_d        = pc_plus4;
      instr_d     = 32'd0;
      pc4_d       = 32'd0;
      valid_d     = 1'b0;
      load_bubble = 1'b1;
    end else begin
      pc_d       = pc_plus4;
      instr_d    = imemData;
      pc4_d      = pc_plus4;
      valid_d    = 1'b1;
      load_fetch = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Counters only advance on edges that actually load IF/ID, so stalls leave them unchanged.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (load_fetch) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end else if (load_bubble) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end else begin
      fetch_cnt_d  = fetch_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetchCount  = fetch_cnt_q;
  assign bubbleCount = bubble_cnt_q;
`else
  logic unused_cnt_s;
  assign unused_cnt_s = load_fetch ^ load_bubble;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by randomized traffic,
// compared against a behavioural fetch model (counters checked when IF_PERF_CNT_EN is set).
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          ADDR_W   = 14;

  logic              clk = 1'b0;
  logic              rst, stall, flush, branchTaken, jump;
  logic [31:0]       branchTarget, jumpTarget;
  logic [ADDR_W-1:0] imemAddr;
  logic              imemRd;
  logic [31:0]       imemData;
  logic [31:0]       pc, ifidInstr, ifidPc4;
  logic              ifidValid;
`ifdef IF_PERF_CNT_EN
  logic [31:0]       fetchCount, bubbleCount;
`endif

  logic [31:0] imem [0:(1<<ADDR_W)-1];

  // Reference state
  logic [31:0] m_pc, m_instr, m_pc4, m_fc, m_bc;
  logic        m_valid;

  int checks = 0;
  int errors = 0;

  if_stage #(.RESET_PC(RESET_PC), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jump(jump), .jumpTarget(jumpTarget),
    .imemAddr(imemAddr), .imemRd(imemRd), .imemData(imemData),
    .pc(pc), .ifidInstr(ifidInstr), .ifidPc4(ifidPc4), .ifidValid(ifidValid)
`ifdef IF_PERF_CNT_EN
    , .fetchCount(fetchCount), .bubbleCount(bubbleCount)
`endif
  );

  always #5 clk = ~clk;

  assign imemData = imem[imemAddr];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the fetch rules, then compare.
  task automatic step(input logic r, input logic s, input logic f,
                      input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    logic [31:0] word;
    rst = r; stall = s; flush = f;
    branchTaken = b; branchTarget = bt; jump = j; jumpTarget = jt;
    #1;
    check_eq("imemRd", {31'd0, imemRd}, {31'd0, ~r});
    check_eq("imemAddr", {18'd0, imemAddr}, (m_pc / 32'd4) % 32'd16384);
    word = imem[(m_pc / 32'd4) % 32'd16384];
    if (r) begin
      m_pc = RESET_PC; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fc = 0; m_bc = 0;
    end else if (b || j) begin
      m_pc = (b ? bt : jt) / 32'd4 * 32'd4;
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_bc = m_bc + 1;
    end else if (s) begin
      m_pc = m_pc;
    end else if (f) begin
      m_pc = m_pc + 4; m_instr = 0; m_pc4 = 0; m_valid = 0; m_bc = m_bc + 1;
    end else begin
      m_instr = word; m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1; m_fc = m_fc + 1;
    end
    @(posedge clk);
    #1;
    check_eq("pc", pc, m_pc);
    check_eq("ifidInstr", ifidInstr, m_instr);
    check_eq("ifidPc4", ifidPc4, m_pc4);
    check_eq("ifidValid", {31'd0, ifidValid}, {31'd0, m_valid});
`ifdef IF_PERF_CNT_EN
    check_eq("fetchCount", fetchCount, m_fc);
    check_eq("bubbleCount", bubbleCount, m_bc);
`endif
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) imem[i] = $urandom;
    imem[0] = 32'h2008_0002;
    imem[1] = 32'h2009_0003;
    imem[2] = 32'h0109_5020;
    m_pc = 32'hDEAD_BEEF; m_instr = 0; m_pc4 = 0; m_valid = 0; m_fc = 0; m_bc = 0;
    rst = 1'b1; stall = 0; flush = 0; branchTaken = 0; jump = 0;
    branchTarget = 0; jumpTarget = 0;
    @(posedge clk);
    #1;
    m_pc = RESET_PC;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("reset_pc", pc, 32'h0);

    // Free run through the first three words.
    idle(); idle();
    check_eq("run_instr2", ifidInstr, 32'h2009_0003);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    check_eq("stall_pc", pc, 32'h8);
    check_eq("stall_addr", {18'd0, imemAddr}, 32'd2);
    idle();
    check_eq("resume_instr", ifidInstr, 32'h0109_5020);
    check_eq("resume_pc", pc, 32'hC);

    // Branch and jump together with stall: branch wins, target aligned.
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0042, 1'b1, 32'h0000_0100);
    check_eq("branch_pc", pc, 32'h40);
    idle();
    check_eq("branch_pc4", ifidPc4, 32'h44);

    // Jump to top of memory wraps pc to 0.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
    check_eq("top_addr", {18'd0, imemAddr}, 32'h3FFF);
    idle();
    check_eq("wrap_pc", pc, 32'h0);
    check_eq("wrap_pc4", ifidPc4, 32'h0);

    // Flush alone, then reset during a stall.
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'd0);
    check_eq("rst_stall_valid", {31'd0, ifidValid}, 32'd0);
    idle();
    check_eq("post_rst_instr", ifidInstr, 32'h2008_0002);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 7) == 0), $urandom,
           ($urandom_range(0, 7) == 0), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
